// File: rtl/and_priority_encoder.sv
// and_priority_encoder
//   Sparse-match front end for the NPU MAC datapath. ANDs the IFM non-zero
//   bitmap with the filter non-zero bitmap, finds the lowest set bit of the
//   result with a binary-tree priority encoder, and registers the outcome
//   for the chunk-walking control logic (1-cycle latency, 1 pair/cycle).
//
// Ports
//   clk_i        : clock, rising edge
//   rst_i        : synchronous reset, active low
//   valid_i      : ifm_i/filter_i are valid this cycle
//   ifm_i        : IFM non-zero bitmap (N bits)
//   filter_i     : filter non-zero bitmap (N bits)
//   and_o        : registered ifm_i & filter_i
//   enc_o        : registered lowest-set-bit index of the AND, N if none
//   match_addr_o : enc_o[IDX_W-1:0]
//   valid_o      : registered, a match was found on a valid input
//   last_o       : registered, the match is the only set bit of the AND
module and_priority_encoder #(
  parameter int unsigned PREFIX_SUM_SIZE = 64,
  parameter int unsigned IDX_W           = $clog2(PREFIX_SUM_SIZE)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       valid_i,
  input  logic [PREFIX_SUM_SIZE-1:0] ifm_i,
  input  logic [PREFIX_SUM_SIZE-1:0] filter_i,
  output logic [PREFIX_SUM_SIZE-1:0] and_o,
  output logic [IDX_W:0]             enc_o,
  output logic [IDX_W-1:0]           match_addr_o,
  output logic                       valid_o,
  output logic                       last_o
);

  localparam int unsigned N = PREFIX_SUM_SIZE;

  // "No match" encoding: MSB set, index bits zero (numerically N).
  localparam logic [IDX_W:0] ENC_NONE = {1'b1, {IDX_W{1'b0}}};

  logic [N-1:0]     and_w;
  logic             found_w;
  logic [IDX_W-1:0] idx_w;
  logic [IDX_W:0]   enc_w;
  logic [N-1:0]     sel_w;
  logic [N-1:0]     next_w;

  assign and_w = ifm_i & filter_i;

  // Binary-tree encoder. Level l has N>>(l+1) nodes; each node covers
  // 2^(l+1) input bits and reports whether any bit is set plus the
  // (l+1)-bit offset of the lowest set bit inside its span. The lower
  // child always wins, so bit 0 has the highest priority. Node j's
  // offset lives at idx[j*(l+1) +: l+1].
  for (genvar l = 0; l < IDX_W; l++) begin : g_lvl
    localparam int unsigned NODES = N >> (l + 1);
    logic [NODES-1:0]         found;
    logic [NODES*(l+1)-1:0]   idx;

    for (genvar j = 0; j < NODES; j++) begin : g_node
      if (l == 0) begin : g_leaf
        assign found[j] = and_w[2*j] | and_w[2*j+1];
        assign idx[j]   = ~and_w[2*j];
      end else begin : g_inner
        logic         f_lo;
        logic         f_hi;
        logic [l-1:0] i_lo;
        logic [l-1:0] i_hi;

        assign f_lo = g_lvl[l-1].found[2*j];
        assign f_hi = g_lvl[l-1].found[2*j+1];
        assign i_lo = g_lvl[l-1].idx[(2*j)*l +: l];
        assign i_hi = g_lvl[l-1].idx[(2*j+1)*l +: l];

        assign found[j]            = f_lo | f_hi;
        assign idx[j*(l+1) +: l+1] = f_lo ? {1'b0, i_lo} : {1'b1, i_hi};
      end
    end
  end

  assign found_w = g_lvl[IDX_W-1].found[0];
  assign idx_w   = g_lvl[IDX_W-1].idx;

  always_comb begin
    enc_w = ENC_NONE;
    if (found_w) begin
      enc_w = {1'b0, idx_w};
    end
  end

  // AND with the winning bit cleared; zero means the match was the last one.
  always_comb begin
    sel_w  = {{(N-1){1'b0}}, 1'b1} << idx_w;
    next_w = '0;
    if (found_w) begin
      next_w = and_w & ~sel_w;
    end
  end

  logic [N-1:0]   and_q,   and_d;
  logic [IDX_W:0] enc_q,   enc_d;
  logic           valid_q, valid_d;
  logic           last_q,  last_d;

  always_comb begin
    and_d   = and_q;
    enc_d   = enc_q;
    valid_d = 1'b0;
    last_d  = 1'b0;
    if (valid_i) begin
      and_d   = and_w;
      enc_d   = enc_w;
      valid_d = (enc_w != ENC_NONE);
      last_d  = found_w && (next_w == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      and_q   <= '0;
      enc_q   <= ENC_NONE;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      and_q   <= and_d;
      enc_q   <= enc_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign and_o        = and_q;
  assign enc_o        = enc_q;
  assign match_addr_o = enc_q[IDX_W-1:0];
  assign valid_o      = valid_q;
  assign last_o       = last_q;

endmodule

// File: tb/tb_and_priority_encoder.sv
// Bench for and_priority_encoder: one N=64 and one N=8 instance fed the
// same stimulus (the N=8 one sees the low byte). A linear-scan/popcount
// model predicts every output each cycle; directed vectors carry literal
// expectations as well.
module tb_and_priority_encoder;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [63:0] ifm;
  logic [63:0] flt;

  logic [63:0] and64;
  logic [6:0]  enc64;
  logic [5:0]  addr64;
  logic        valid64;
  logic        last64;

  logic [7:0]  and8;
  logic [3:0]  enc8;
  logic [2:0]  addr8;
  logic        valid8;
  logic        last8;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  and_priority_encoder #(.PREFIX_SUM_SIZE(64)) dut64 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid),
    .ifm_i(ifm), .filter_i(flt),
    .and_o(and64), .enc_o(enc64), .match_addr_o(addr64),
    .valid_o(valid64), .last_o(last64)
  );

  and_priority_encoder #(.PREFIX_SUM_SIZE(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid),
    .ifm_i(ifm[7:0]), .filter_i(flt[7:0]),
    .and_o(and8), .enc_o(enc8), .match_addr_o(addr8),
    .valid_o(valid8), .last_o(last8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) if (v[i]) return i;
    return n;
  endfunction

  function automatic int popc(input logic [63:0] v);
    int c = 0;
    for (int i = 0; i < 64; i++) c += int'(v[i]);
    return c;
  endfunction

  // Reference model: what each instance must show after this edge.
  logic [63:0] m_and64, m_and8;
  int          m_enc64, m_enc8;
  logic        m_v64, m_l64, m_v8, m_l8;

  always @(posedge clk) begin
    if (!rst) begin
      m_and64 <= '0;  m_enc64 <= 64; m_v64 <= 1'b0; m_l64 <= 1'b0;
      m_and8  <= '0;  m_enc8  <= 8;  m_v8  <= 1'b0; m_l8  <= 1'b0;
    end else if (valid) begin
      m_and64 <= ifm & flt;
      m_enc64 <= lowest(ifm & flt, 64);
      m_v64   <= popc(ifm & flt) != 0;
      m_l64   <= popc(ifm & flt) == 1;
      m_and8  <= (ifm & flt) & 64'hFF;
      m_enc8  <= lowest((ifm & flt) & 64'hFF, 8);
      m_v8    <= popc((ifm & flt) & 64'hFF) != 0;
      m_l8    <= popc((ifm & flt) & 64'hFF) == 1;
    end else begin
      m_v64 <= 1'b0; m_l64 <= 1'b0;
      m_v8  <= 1'b0; m_l8  <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("and64",   and64,   m_and64);
      check("enc64",   64'(enc64), 64'(m_enc64));
      check("addr64",  64'(addr64), 64'(m_enc64 % 64));
      check("valid64", 64'(valid64), 64'(m_v64));
      check("last64",  64'(last64), 64'(m_l64));
      check("and8",    64'(and8), m_and8);
      check("enc8",    64'(enc8), 64'(m_enc8));
      check("addr8",   64'(addr8), 64'(m_enc8 % 8));
      check("valid8",  64'(valid8), 64'(m_v8));
      check("last8",   64'(last8), 64'(m_l8));
    end
  end

  // Drive one cycle; outputs for it are visible on return.
  task automatic apply(input logic [63:0] a, input logic [63:0] b, input logic v, input logic r);
    ifm = a; flt = b; valid = v; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic expect64(input string tag, input logic [63:0] a, input int e,
                          input logic v, input logic l);
    check({tag, ".and"},   and64, a);
    check({tag, ".enc"},   64'(enc64), 64'(e));
    check({tag, ".addr"},  64'(addr64), 64'(e % 64));
    check({tag, ".valid"}, 64'(valid64), 64'(v));
    check({tag, ".last"},  64'(last64), 64'(l));
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [63:0] rnd_density();
    logic [63:0] v;
    int k;
    k = int'($urandom_range(0, 5));
    if (k == 5) begin
      v = 64'd1 << $urandom_range(0, 63);
    end else begin
      v = '1;
      for (int i = 0; i < k; i++) v &= rnd64();
    end
    return v;
  endfunction

  initial begin
    rst = 1'b0; valid = 1'b0; ifm = '0; flt = '0;

    // Reset held low with valid high and random bitmaps.
    apply(rnd64(), rnd64(), 1'b1, 1'b0);
    chk_en = 1'b1;
    apply(rnd64(), rnd64(), 1'b1, 1'b0);
    expect64("reset", 64'h0, 64, 1'b0, 1'b0);
    check("reset.enc8", 64'(enc8), 64'd8);

    apply(64'h00F0, 64'h0F30, 1'b1, 1'b1);
    expect64("basic", 64'h30, 4, 1'b1, 1'b0);

    apply(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 1'b1);
    expect64("nooverlap", 64'h0, 64, 1'b0, 1'b0);

    apply(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b1);
    expect64("bit63", 64'h8000_0000_0000_0000, 63, 1'b1, 1'b1);
    check("bit63.enc8", 64'(enc8), 64'd8);

    apply('1, '1, 1'b1, 1'b1);
    expect64("allones", '1, 0, 1'b1, 1'b0);
    check("allones.last8", 64'(last8), 64'd0);

    apply(64'h0000_0100_0000_0000, 64'hFFFF_FF00_0000_0000, 1'b1, 1'b1);
    expect64("single40", 64'h0000_0100_0000_0000, 40, 1'b1, 1'b1);

    // Valid gating: registered data holds, flags drop.
    apply(64'h00F0, 64'h0F30, 1'b1, 1'b1);
    apply(64'h0001, 64'h0001, 1'b0, 1'b1);
    expect64("gate", 64'h30, 4, 1'b0, 1'b0);
    apply(64'h0003, 64'h0006, 1'b0, 1'b1);
    expect64("gate2", 64'h30, 4, 1'b0, 1'b0);

    // Reset mid-stream, then resume.
    apply(64'h0C00, 64'h0800, 1'b1, 1'b0);
    expect64("midreset", 64'h0, 64, 1'b0, 1'b0);
    apply(64'h0C00, 64'h0C00, 1'b1, 1'b1);
    expect64("resume", 64'h0C00, 10, 1'b1, 1'b0);

    // Random regression, model-checked every cycle.
    for (int n = 0; n < 10000; n++) begin
      apply(rnd_density(), rnd_density(),
            ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 63) != 0));
    end

    chk_en = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/and_priority_encoder.md
Name: and_priority_encoder

Overview:
- Sparse-match front end for the NPU MAC datapath.
- Bitwise-ANDs an IFM non-zero bitmap with a filter non-zero bitmap.
- Priority-encodes the result to the index of the lowest set bit.
- Registers the result one cycle later for the chunk-walking control logic.

Parameters:
- PREFIX_SUM_SIZE, 64, bitmap width N in bits. Must be a power of two and at least 2.
- IDX_W, $clog2(PREFIX_SUM_SIZE), width of the match index. Derived; do not override.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, synchronous, active-low (asserted when 0).
- valid_i  input  1  input bitmaps are valid this cycle.
- ifm_i  input  N  IFM non-zero bitmap.
- filter_i  input  N  filter non-zero bitmap.
- and_o  output  N  registered ifm_i & filter_i.
- enc_o  output  IDX_W+1  registered encoder result. Index of the lowest set bit of the AND, or N if no bit is set.
- match_addr_o  output  IDX_W  enc_o[IDX_W-1:0].
- valid_o  output  1  registered: a match was found on a valid input.
- last_o  output  1  registered: the found match is the only set bit (AND has exactly one set bit).

Behaviour:
- Combinational stage:
  - and_w = ifm_i & filter_i.
  - enc_w = index of the lowest-numbered set bit of and_w. Bit 0 has highest priority.
  - enc_w = N (MSB set, index bits all 0) when and_w == 0.
- Encoder structure: log2(N)-level binary tree of 2:1 "found/index" nodes. No linear N-input priority chain. Result must equal the linear-scan definition for every input.
- next_w = and_w with bit enc_w[IDX_W-1:0] cleared when and_w != 0; otherwise 0.
- Register stage, on every rising clk_i:
  - rst_i == 0: and_o = 0, enc_o = N, valid_o = 0, last_o = 0. Reset has priority over valid_i.
  - rst_i == 1 and valid_i == 1: and_o <= and_w; enc_o <= enc_w; valid_o <= (enc_w != N); last_o <= (and_w != 0) && (next_w == 0).
  - rst_i == 1 and valid_i == 0: and_o and enc_o hold; valid_o <= 0; last_o <= 0.
- Latency: exactly 1 cycle from inputs to outputs. Throughput: one bitmap pair per cycle, no backpressure.
- match_addr_o is don't-care when valid_o == 0. It is still driven as enc_o[IDX_W-1:0], so it reads 0 after reset and when no match is found.
- Boundary cases:
  - all-zero AND → enc_o = N, valid_o = 0, last_o = 0.
  - only bit N-1 set → enc_o = N-1, valid_o = 1, last_o = 1.
  - all ones → enc_o = 0, valid_o = 1, last_o = 0.
- Reset mid-stream: outputs return to reset values on the edge where rst_i is sampled low. Operation resumes on the first edge with rst_i high and valid_i high.
- No X propagation: with known inputs, all outputs are known from the first reset edge.

Test Plan:
- Reset: hold rst_i=0 for 2 cycles with valid_i=1 and random bitmaps → and_o=0, enc_o=64, valid_o=0, last_o=0.
- Basic match: ifm_i=0x...00F0, filter_i=0x...0F30, valid_i=1 → next cycle and_o=0x30, enc_o=4, match_addr_o=4, valid_o=1, last_o=0.
- No overlap: ifm_i=0xAAAA..., filter_i=0x5555... → and_o=0, enc_o=64, valid_o=0, last_o=0.
- Single/extreme bits:
  - only bit 63 set in both → enc_o=63, valid_o=1, last_o=1.
  - both all-ones → enc_o=0, last_o=0.
- Valid gating: valid_i=1 with a match, then valid_i=0 with different bitmaps → outputs hold and_o/enc_o, valid_o=0, last_o=0.
- Random regression: 10k random pairs at varying densities (N=64 and N=8) → enc_o equals a linear lowest-set-bit model each cycle; valid_o/last_o match the popcount-based model.
